// File: rtl/bounce_box_pic.sv
// bounce_box_pic: test-pattern generator drawing a square that bounces
// around the visible area, changing colour every time it hits an edge.
//
// Ports
//   vga_clk    - pixel clock, all state on its rising edge
//   vga_rst    - asynchronous active-high reset
//   x_pos      - current column from the VGA timing stage
//   y_pos      - current row from the VGA timing stage
//   pixel_data - registered colour {R[11:8],G[7:4],B[3:0]}, one cycle latency
//   frame_tick - one-cycle pulse aligned with each box position update
module bounce_box_pic #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned STEP     = 2,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  output logic [11:0] pixel_data,
  output logic        frame_tick
);

  // 11-bit constants so that position + size sums never wrap
  localparam logic [10:0] H_W    = 11'(H_ACTIVE);
  localparam logic [10:0] V_W    = 11'(V_ACTIVE);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  STEP_P = 10'(STEP);
  localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);

  typedef enum logic [1:0] {
    COL_RED,
    COL_GREEN,
    COL_BLUE,
    COL_WHITE
  } color_e;

  color_e      color_q, color_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic        match_q, match_d;
  logic        tick_q, tick_d;
  logic [11:0] pix_q, pix_d;

  logic        frame_evt;
  logic        x_hit, y_hit;
  logic [9:0]  box_x_n, box_y_n;
  logic        dir_x_n, dir_y_n;
  logic [11:0] box_rgb;
  logic        visible, in_box;

  // Frame event: rising edge of the last-visible-pixel match
  always_comb begin
    match_d   = (x_pos == H_LAST) && (y_pos == V_LAST);
    frame_evt = match_d && !match_q;
    tick_d    = frame_evt;
  end

  // Candidate next horizontal position, evaluated every cycle
  always_comb begin
    x_hit   = 1'b0;
    box_x_n = box_x_q;
    dir_x_n = dir_x_q;
    if (!dir_x_q) begin
      if ({1'b0, box_x_q} + STEP_W + BOX_W >= H_W) begin
        x_hit   = 1'b1;
        box_x_n = X_MAX;
        dir_x_n = 1'b1;
      end else begin
        box_x_n = box_x_q + STEP_P;
      end
    end else begin
      if ({1'b0, box_x_q} < STEP_W) begin
        x_hit   = 1'b1;
        box_x_n = '0;
        dir_x_n = 1'b0;
      end else begin
        box_x_n = box_x_q - STEP_P;
      end
    end
  end

  // Candidate next vertical position
  always_comb begin
    y_hit   = 1'b0;
    box_y_n = box_y_q;
    dir_y_n = dir_y_q;
    if (!dir_y_q) begin
      if ({1'b0, box_y_q} + STEP_W + BOX_W >= V_W) begin
        y_hit   = 1'b1;
        box_y_n = Y_MAX;
        dir_y_n = 1'b1;
      end else begin
        box_y_n = box_y_q + STEP_P;
      end
    end else begin
      if ({1'b0, box_y_q} < STEP_W) begin
        y_hit   = 1'b1;
        box_y_n = '0;
        dir_y_n = 1'b0;
      end else begin
        box_y_n = box_y_q - STEP_P;
      end
    end
  end

  // Candidates are committed only on a frame event
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (frame_evt) begin
      box_x_d = box_x_n;
      box_y_d = box_y_n;
      dir_x_d = dir_x_n;
      dir_y_d = dir_y_n;
    end
  end

  // Colour FSM next state: a corner hit still advances a single step
  always_comb begin
    color_d = color_q;
    if (frame_evt && (x_hit || y_hit)) begin
      case (color_q)
        COL_RED:   color_d = COL_GREEN;
        COL_GREEN: color_d = COL_BLUE;
        COL_BLUE:  color_d = COL_WHITE;
        default:   color_d = COL_RED;
      endcase
    end
  end

  // Colour FSM output
  always_comb begin
    box_rgb = 12'hF00;
    case (color_q)
      COL_RED:   box_rgb = 12'hF00;
      COL_GREEN: box_rgb = 12'h0F0;
      COL_BLUE:  box_rgb = 12'h00F;
      default:   box_rgb = 12'hFFF;
    endcase
  end

  // Pixel colour uses the pre-update box state in the event cycle
  always_comb begin
    visible = ({1'b0, x_pos} < H_W) && ({1'b0, y_pos} < V_W);
    in_box  = ({1'b0, x_pos} >= {1'b0, box_x_q}) &&
              ({1'b0, x_pos} <  {1'b0, box_x_q} + BOX_W) &&
              ({1'b0, y_pos} >= {1'b0, box_y_q}) &&
              ({1'b0, y_pos} <  {1'b0, box_y_q} + BOX_W);
    pix_d = 12'h000;
    if (visible) begin
      pix_d = in_box ? box_rgb : BG_COLOR;
    end
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      color_q <= COL_RED;
      match_q <= 1'b0;
      tick_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      color_q <= color_d;
      match_q <= match_d;
      tick_q  <= tick_d;
      pix_q   <= pix_d;
    end
  end

  assign pixel_data = pix_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bounce_box_pic.sv
module tb_bounce_box_pic;

  localparam logic [11:0] BG_A = 12'h135;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  xa, ya, xb, yb;
  logic [11:0] pix_a, pix_b;
  logic        tick_a, tick_b;

  always #5 clk = ~clk;

  bounce_box_pic #(
    .H_ACTIVE(640), .V_ACTIVE(480), .BOX_SIZE(32), .STEP(2), .BG_COLOR(BG_A)
  ) u_main (
    .vga_clk(clk), .vga_rst(rst), .x_pos(xa), .y_pos(ya),
    .pixel_data(pix_a), .frame_tick(tick_a)
  );

  bounce_box_pic #(
    .H_ACTIVE(64), .V_ACTIVE(64), .BOX_SIZE(32), .STEP(2)
  ) u_sq (
    .vga_clk(clk), .vga_rst(rst), .x_pos(xb), .y_pos(yb),
    .pixel_data(pix_b), .frame_tick(tick_b)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int bx, by;
    bit dx, dy;
    int col;
    int h, v;
    int evs;
  } mdl_t;

  typedef struct {
    int          src;
    string       tag;
    logic [11:0] exp;
  } sb_t;

  mdl_t ma, mb;
  bit   prev_a, prev_b;
  sb_t  sbq[$];

  function automatic logic [11:0] rgb(int c);
    case (c)
      0:       return 12'hF00;
      1:       return 12'h0F0;
      2:       return 12'h00F;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic mdl_t mdl_init(int h, int v);
    mdl_t m;
    m.bx = 0; m.by = 0; m.dx = 0; m.dy = 0; m.col = 0;
    m.h = h; m.v = v; m.evs = 0;
    return m;
  endfunction

  function automatic mdl_t adv(mdl_t m);
    bit hx = 0, hy = 0;
    if (!m.dx) begin
      if (m.bx + 2 + 32 >= m.h) begin m.bx = m.h - 32; m.dx = 1; hx = 1; end
      else m.bx = m.bx + 2;
    end else if (m.bx < 2) begin m.bx = 0; m.dx = 0; hx = 1; end
    else m.bx = m.bx - 2;
    if (!m.dy) begin
      if (m.by + 2 + 32 >= m.v) begin m.by = m.v - 32; m.dy = 1; hy = 1; end
      else m.by = m.by + 2;
    end else if (m.by < 2) begin m.by = 0; m.dy = 0; hy = 1; end
    else m.by = m.by - 2;
    if (hx || hy) m.col = (m.col + 1) % 4;
    m.evs++;
    return m;
  endfunction

  function automatic logic [11:0] exp_pix(mdl_t m, int x, int y, logic [11:0] bg);
    if (x >= m.h || y >= m.v) return 12'h000;
    if (x >= m.bx && x < m.bx + 32 && y >= m.by && y < m.by + 32) return rgb(m.col);
    return bg;
  endfunction

  task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ma = mdl_init(640, 480);
    mb = mdl_init(64, 64);
    prev_a = 0;
    prev_b = 0;
  endtask

  // Entered at a falling edge; drives one pixel per instance, checks the
  // registered outputs one cycle later and returns at the next falling edge.
  task automatic cyc(int ax, int ay, int bxp, int byp);
    bit          ea, eb, ma_now, mb_now;
    sb_t         e;
    logic [11:0] obs;
    xa = 10'(ax); ya = 10'(ay); xb = 10'(bxp); yb = 10'(byp);
    ma_now = (ax == 639 && ay == 479);
    mb_now = (bxp == 63 && byp == 63);
    ea = ma_now && !prev_a;
    eb = mb_now && !prev_b;
    prev_a = ma_now;
    prev_b = mb_now;
    sbq.push_back('{0, "pix_a", exp_pix(ma, ax, ay, BG_A)});
    sbq.push_back('{1, "tick_a", {11'b0, ea}});
    sbq.push_back('{2, "pix_b", exp_pix(mb, bxp, byp, 12'h000)});
    sbq.push_back('{3, "tick_b", {11'b0, eb}});
    @(posedge clk);
    #1;
    if (ea) ma = adv(ma);
    if (eb) mb = adv(mb);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.src)
        0:       obs = pix_a;
        1:       obs = {11'b0, tick_a};
        2:       obs = pix_b;
        default: obs = {11'b0, tick_b};
      endcase
      chk(e.tag, obs, e.exp);
    end
    @(negedge clk);
  endtask

  task automatic ev_a();
    cyc(639, 479, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic ev_b();
    cyc(0, 0, 63, 63);
    cyc(0, 0, 0, 0);
  endtask

  task automatic chk_regs_a();
    chk("box_x_a", 12'(u_main.box_x_q), 12'(ma.bx));
    chk("box_y_a", 12'(u_main.box_y_q), 12'(ma.by));
    chk("dir_x_a", 12'(u_main.dir_x_q), 12'(ma.dx));
    chk("dir_y_a", 12'(u_main.dir_y_q), 12'(ma.dy));
  endtask

  task automatic chk_regs_b();
    chk("box_x_b", 12'(u_sq.box_x_q), 12'(mb.bx));
    chk("box_y_b", 12'(u_sq.box_y_q), 12'(mb.by));
    chk("dir_x_b", 12'(u_sq.dir_x_q), 12'(mb.dx));
    chk("dir_y_b", 12'(u_sq.dir_y_q), 12'(mb.dy));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    xa = '0; ya = '0; xb = '0; yb = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pix_a", pix_a, 12'h000);
    chk("rst_tick_a", {11'b0, tick_a}, 12'h000);
    chk("rst_pix_b", pix_b, 12'h000);
    chk_regs_a();
    rst = 1'b0;

    // Scan from reset: box red at the origin
    cyc(0, 0, 0, 0);
    cyc(31, 31, 31, 31);
    cyc(15, 7, 15, 7);
    cyc(32, 0, 32, 0);
    cyc(640, 0, 640, 0);
    cyc(0, 480, 0, 480);
    cyc(31, 32, 31, 32);
    cyc(639, 0, 63, 0);

    // Single frame event
    ev_a();
    chk_regs_a();
    chk("one_ev_box_x", 12'(u_main.box_x_q), 12'd2);
    cyc(1, 1, 0, 0);
    cyc(2, 2, 0, 0);
    cyc(33, 33, 0, 0);
    cyc(34, 34, 0, 0);
    cyc(2, 1, 0, 0);

    // Holding the last pixel yields one event only
    for (int i = 0; i < 5; i++) cyc(639, 479, 0, 0);
    cyc(0, 0, 0, 0);
    chk_regs_a();
    chk("hold_box_x", 12'(u_main.box_x_q), 12'd4);

    // Run up to the right-hand wall
    while (ma.evs < 303) ev_a();
    chk_regs_a();
    chk("pre_hit_box_x", 12'(u_main.box_x_q), 12'd606);
    ev_a();
    chk_regs_a();
    chk("x_hit_box_x", 12'(u_main.box_x_q), 12'd608);
    chk("x_hit_dir_x", 12'(u_main.dir_x_q), 12'd1);
    cyc(ma.bx, ma.by, 0, 0);
    cyc(ma.bx - 1, ma.by, 0, 0);
    ev_a();
    chk_regs_a();
    chk("after_hit_box_x", 12'(u_main.box_x_q), 12'd606);

    // Corner hit on the 64x64 instance
    for (int i = 0; i < 15; i++) ev_b();
    chk_regs_b();
    cyc(0, 0, 30, 30);
    ev_b();
    chk_regs_b();
    chk("corner_dir_x", 12'(u_sq.dir_x_q), 12'd1);
    chk("corner_dir_y", 12'(u_sq.dir_y_q), 12'd1);
    chk("corner_color", 12'(u_sq.color_q), 12'd1);
    cyc(0, 0, 32, 32);
    cyc(0, 0, 31, 31);
    cyc(0, 0, 63, 63);

    // Fresh start, then asynchronous reset mid-frame right after an event
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    while (ma.evs < 49) ev_a();
    cyc(639, 479, 0, 0);
    chk("pre_rst_box_x", 12'(u_main.box_x_q), 12'd100);
    #2;
    rst = 1'b1;
    #1;
    chk("async_pix_a", pix_a, 12'h000);
    chk("async_tick_a", {11'b0, tick_a}, 12'h000);
    chk("async_color", 12'(u_main.color_q), 12'd0);
    model_reset();
    chk_regs_a();
    @(posedge clk);
    #1;
    chk("rst_held_pix_a", pix_a, 12'h000);
    chk("rst_held_box_x", 12'(u_main.box_x_q), 12'd0);
    @(negedge clk);
    rst = 1'b0;
    // Last pixel still held: first post-reset event is recognised
    cyc(639, 479, 0, 0);
    chk_regs_a();
    cyc(0, 0, 0, 0);
    cyc(2, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
